// File: rtl/aes_engine_pkg.sv
// Shared types, tables and byte helpers for the AES-128 engine.
// AES_STALL_CNT_EN adds the stall_cnt field to flags_engine_t.
package aes_package;

  localparam int AES_DW       = 32;
  localparam int AES_N_ROUNDS = 10;
  localparam int AES_CNT_W    = 16;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, EMIT} aes_engine_state_t;

  typedef struct packed {
    logic                 start;
    logic                 enable;
    logic                 clear;
    logic [AES_CNT_W-1:0] nb_blocks;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [AES_CNT_W-1:0] blk_cnt;
`ifdef AES_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif
  } flags_engine_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_engine_round.sv
// One combinational AES-128 round plus the matching key-schedule step.
// Byte i of the state sits at [127-8*i -: 8] (column-major, FIPS-197 order).
module aes_round
  import aes_package::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  input  logic         i_last,
  output logic [127:0] o_next_state,
  output logic [127:0] o_next_rk
);

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [31:0]  w_t;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign w_t  = sub_word(rot_word(i_rk[31:0])) ^ {i_rcon, 24'h0};
  assign w_k0 = i_rk[127:96] ^ w_t;
  assign w_k1 = i_rk[95:64]  ^ w_k0;
  assign w_k2 = i_rk[63:32]  ^ w_k1;
  assign w_k3 = i_rk[31:0]   ^ w_k2;
  assign o_next_rk = {w_k0, w_k1, w_k2, w_k3};

  always_comb begin
    w_sb = '0;
    w_sr = '0;
    w_mc = '0;
    for (int i = 0; i < 16; i++)
      w_sb[127-8*i -: 8] = SBOX[i_state[127-8*i -: 8]];
    // row r of column c takes the byte from column (c+r) mod 4
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++)
      w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    o_next_state = (i_last ? w_sr : w_mc) ^ o_next_rk;
  end

endmodule

// File: rtl/aes_engine.sv
// Iterative AES-128 encryption engine: 4-word load, 10 rounds, 4-word emit.
// Optional build macro AES_STALL_CNT_EN adds a saturating ciphertext stall counter.
module aes_engine
  import aes_package::*;
#(
  parameter int DW       = 32,
  parameter int N_ROUNDS = AES_N_ROUNDS,
  parameter int CNT_W    = AES_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  ctrl_engine_t  ctrl_i,
  input  logic [127:0]  key_i,
  input  logic [DW-1:0] pt_data_i,
  input  logic          pt_valid_i,
  output logic          pt_ready_o,
  output logic [DW-1:0] ct_data_o,
  output logic          ct_valid_o,
  input  logic          ct_ready_i,
  output flags_engine_t flags_o
);

  if (DW != 32 || N_ROUNDS != AES_N_ROUNDS || CNT_W != AES_CNT_W) begin : g_param_check
    $error("aes_engine: only DW=32, N_ROUNDS=10, CNT_W=16 are supported");
  end

  aes_engine_state_t r_state, w_state_nxt;
  logic [127:0]      r_k;
  logic [127:0]      r_st;
  logic [127:0]      r_rk;
  logic [CNT_W-1:0]  r_nb;
  logic [CNT_W-1:0]  r_blk;
  logic [1:0]        r_wcnt;
  logic [3:0]        r_rnd;
  logic              r_done;

  logic              w_clr;
  logic              w_en;
  logic              w_pt_fire;
  logic              w_ct_fire;
  logic              w_last_word;
  logic              w_last_round;
  logic              w_job_done;
  logic [7:0]        w_rcon;
  logic [127:0]      w_next_state;
  logic [127:0]      w_next_rk;

  assign w_clr        = reset | clear | ctrl_i.clear;
  assign w_en         = ctrl_i.enable;
  assign w_pt_fire    = (r_state == LOAD) && pt_valid_i && w_en;
  assign w_ct_fire    = (r_state == EMIT) && ct_ready_i && w_en;
  assign w_last_word  = (r_wcnt == 2'd3);
  assign w_last_round = (r_rnd == 4'(N_ROUNDS));
  assign w_job_done   = ((r_blk + CNT_W'(1)) == r_nb);
  assign w_rcon       = (r_rnd >= 4'd1 && r_rnd <= 4'(N_ROUNDS)) ? RCON[r_rnd - 4'd1] : 8'h00;

  aes_round u_round (
    .i_state      (r_st),
    .i_rk         (r_rk),
    .i_rcon       (w_rcon),
    .i_last       (w_last_round),
    .o_next_state (w_next_state),
    .o_next_rk    (w_next_rk)
  );

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_en) begin
      case (r_state)
        IDLE:    if (ctrl_i.start) w_state_nxt = LOAD;
        LOAD:    if (w_pt_fire && w_last_word) w_state_nxt = ROUND;
        ROUND:   if (w_last_round) w_state_nxt = EMIT;
        EMIT:    if (w_ct_fire && w_last_word) w_state_nxt = w_job_done ? IDLE : LOAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_nb   <= '0;
      r_blk  <= '0;
      r_wcnt <= '0;
      r_rnd  <= '0;
      r_done <= 1'b0;
    end else if (w_en) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (ctrl_i.start) begin
          r_nb   <= (ctrl_i.nb_blocks == '0) ? CNT_W'(1) : ctrl_i.nb_blocks;
          r_blk  <= '0;
          r_wcnt <= '0;
        end
        LOAD: if (w_pt_fire) begin
          r_wcnt <= r_wcnt + 2'd1;
          if (w_last_word) r_rnd <= 4'd1;
        end
        ROUND: r_rnd <= r_rnd + 4'd1;
        EMIT: if (w_ct_fire) begin
          r_wcnt <= r_wcnt + 2'd1;
          if (w_last_word) begin
            r_blk  <= r_blk + CNT_W'(1);
            r_done <= w_job_done;
          end
        end
        default: ;
      endcase
    end
  end

  // r_st shifts words in during LOAD and out during EMIT, so word 0 is always at the top
  always_ff @(posedge clk) begin
    if (w_en) begin
      case (r_state)
        IDLE: if (ctrl_i.start) r_k <= key_i;
        LOAD: if (w_pt_fire) begin
          if (w_last_word) begin
            r_st <= {r_st[95:0], pt_data_i} ^ r_k;
            r_rk <= r_k;
          end else begin
            r_st <= {r_st[95:0], pt_data_i};
          end
        end
        ROUND: begin
          r_st <= w_next_state;
          r_rk <= w_next_rk;
        end
        EMIT: if (w_ct_fire) r_st <= {r_st[95:0], 32'h0};
        default: ;
      endcase
    end
  end

`ifdef AES_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_stall <= '0;
    end else if (w_en) begin
      if (r_state == IDLE && ctrl_i.start)
        r_stall <= '0;
      else if (r_state == EMIT && !ct_ready_i && r_stall != '1)
        r_stall <= r_stall + 32'd1;
    end
  end
`endif

  assign pt_ready_o = (r_state == LOAD);
  assign ct_valid_o = (r_state == EMIT);
  assign ct_data_o  = (r_state == EMIT) ? r_st[127:96] : '0;

  always_comb begin
    flags_o         = '0;
    flags_o.busy    = (r_state != IDLE);
    flags_o.done    = r_done;
    flags_o.blk_cnt = r_blk;
`ifdef AES_STALL_CNT_EN
    flags_o.stall_cnt = r_stall;
`endif
  end

endmodule

// File: tb/tb_aes_engine.sv
// Directed and randomized bench for aes_engine against an independent AES-128 model
// whose S-box is derived from GF(2^8) inversion rather than copied from a table.
module tb_aes_engine;
  import aes_package::*;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          reset, clear;
  ctrl_engine_t  ctrl;
  logic [127:0]  key;
  logic [31:0]   pt_data, ct_data;
  logic          pt_valid, pt_ready, ct_valid, ct_ready;
  flags_engine_t flags;

  always #5 clk = ~clk;

  aes_engine dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .ctrl_i     (ctrl),
    .key_i      (key),
    .pt_data_i  (pt_data),
    .pt_valid_i (pt_valid),
    .pt_ready_o (pt_ready),
    .ct_data_o  (ct_data),
    .ct_valid_o (ct_valid),
    .ct_ready_i (ct_ready),
    .flags_o    (flags)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int beat_cyc = 0;
  logic [7:0] ref_sb [256];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (flags.done) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      ref_sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sb[tmp[31:24]], ref_sb[tmp[23:16]], ref_sb[tmp[15:8]], ref_sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] ^= 8'(w[i/4] >> (24 - 8*(i%4)));
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= 8'(w[4*r + i/4] >> (24 - 8*(i%4)));
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic start_job(input logic [127:0] k, input logic [AES_CNT_W-1:0] nb);
    @(negedge clk);
    key = k; ctrl.nb_blocks = nb; ctrl.start = 1'b1;
    @(negedge clk);
    ctrl.start = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] p, input bit gaps);
    int beats;
    beats = 0;
    for (int n = 0; n < 200 && beats < 4; n++) begin
      @(negedge clk);
      pt_data  = p[127-32*beats -: 32];
      pt_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pt_valid && pt_ready) begin
        beats++;
        beat_cyc = cyc + 1;
      end
    end
    check("pt_beats", beats, 4);
    @(posedge clk);
    #1 pt_valid = 1'b0;
  endtask

  task automatic recv_block(output logic [127:0] ct, input bit rand_rdy, output int lat, output int stalls);
    logic [31:0] held;
    bit holding;
    int got;
    got = 0; holding = 0; lat = -1; stalls = 0; ct = '0; held = '0;
    for (int n = 0; n < 400 && got < 4; n++) begin
      @(negedge clk);
      if (holding) check("ct_hold", {ct_valid, ct_data}, {1'b1, held});
      if (ct_valid) begin
        if (lat < 0) lat = cyc - beat_cyc;
        ct_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ct_ready) begin
          ct = {ct[95:0], ct_data};
          got++;
          holding = 0;
        end else begin
          held = ct_data;
          holding = 1;
          stalls++;
        end
      end else begin
        ct_ready = 1'b0;
      end
    end
    check("ct_words", got, 4);
    @(posedge clk);
    #1 ct_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] ct, rk, rp0, rp1;
    int lat, st, st_total, d0;

    ctrl = '0; ctrl.enable = 1'b1;
    reset = 1'b1; clear = 1'b0; key = '0;
    pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("rst_pt_ready", pt_ready, 0);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_ct_data", ct_data, 0);
    check("rst_flags", 128'(flags), 128'h0);
    reset = 1'b0;
    check("model_appB", ref_aes(KB, PB), CB);

    // FIPS-197 App.B, single block
    d0 = done_cnt;
    start_job(KB, 1);
    check("busy_after_start", flags.busy, 1);
    send_block(PB, 0);
    recv_block(ct, 0, lat, st);
    check("appB_ct", ct, CB);
    check("appB_latency", lat, 10);
    repeat (2) @(negedge clk);
    check("appB_done_pulses", done_cnt - d0, 1);
    check("appB_busy_end", flags.busy, 0);
    check("appB_blk_cnt", flags.blk_cnt, 1);

    // FIPS-197 App.C.1, three blocks, key_i scrambled mid-job
    d0 = done_cnt;
    start_job(KC, 3);
    for (int b = 0; b < 3; b++) begin
      send_block(PC, 0);
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      recv_block(ct, 0, lat, st);
      check("appC_ct", ct, CC);
    end
    repeat (2) @(negedge clk);
    check("appC_blk_cnt", flags.blk_cnt, 3);
    check("appC_done_pulses", done_cnt - d0, 1);

    // backpressure and input gaps on App.B
    start_job(KB, 1);
    send_block(PB, 1);
    recv_block(ct, 1, lat, st);
    check("bp_appB_ct", ct, CB);
`ifdef AES_STALL_CNT_EN
    @(negedge clk);
    check("bp_stall_cnt", flags.stall_cnt, st);
`endif

    // random key and data, two blocks, with backpressure
    for (int j = 0; j < 3; j++) begin
      rk  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp0 = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_job(rk, 2);
      send_block(rp0, 1);
      recv_block(ct, 1, lat, st);
      st_total = st;
      check("rand_ct0", ct, ref_aes(rk, rp0));
      send_block(rp1, 1);
      recv_block(ct, 1, lat, st);
      st_total += st;
      check("rand_ct1", ct, ref_aes(rk, rp1));
      @(negedge clk);
      check("rand_blk_cnt", flags.blk_cnt, 2);
`ifdef AES_STALL_CNT_EN
      check("rand_stall_cnt", flags.stall_cnt, st_total);
`endif
    end

    // reset / clear / ctrl clear applied while rnd = 5
    for (int m = 0; m < 3; m++) begin
      start_job(KB, 1);
      send_block(PB, 0);
      @(negedge clk);
      repeat (4) @(negedge clk);
      case (m)
        0:       reset = 1'b1;
        1:       clear = 1'b1;
        default: ctrl.clear = 1'b1;
      endcase
      @(negedge clk);
      reset = 1'b0; clear = 1'b0; ctrl.clear = 1'b0;
      check("clr_pt_ready", pt_ready, 0);
      check("clr_ct_valid", ct_valid, 0);
      check("clr_ct_data", ct_data, 0);
      check("clr_flags", 128'(flags), 128'h0);
      repeat (15) @(negedge clk);
      check("clr_no_emit", ct_valid, 0);
      start_job(KB, 1);
      send_block(PB, 0);
      recv_block(ct, 0, lat, st);
      check("clr_fresh_ct", ct, CB);
    end

    // enable low for 7 cycles during ROUND
    start_job(KB, 1);
    send_block(PB, 0);
    @(negedge clk);
    @(negedge clk);
    ctrl.enable = 1'b0;
    repeat (7) @(negedge clk);
    ctrl.enable = 1'b1;
    recv_block(ct, 0, lat, st);
    check("freeze_ct", ct, CB);
    check("freeze_latency", lat, 17);

    // nb_blocks=0 runs one block; a start while busy is ignored
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    start_job(KB, 0);
    start_job(KC, 5);
    send_block(PB, 0);
    recv_block(ct, 0, lat, st);
    check("nb0_ct", ct, CB);
    repeat (2) @(negedge clk);
    check("nb0_done_pulses", done_cnt - d0, 1);
    check("nb0_blk_cnt", flags.blk_cnt, 1);
    check("nb0_busy", flags.busy, 0);
    repeat (20) @(negedge clk);
    check("nb0_idle_ports", {pt_ready, ct_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
